// File: rtl/pack_pkg.sv
// Shared definitions for the PL->PS stream arbiter.
//   state_t        : arbiter FSM states
//   TERM_WORD_DEF  : default payload of a forced-termination beat
//   GRANT_W        : width of the externally visible grant index
//   ch_idx_w()     : channel-index width for a given channel count
package pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_TERM  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] TERM_WORD_DEF = 32'hDEAD_BEEF;
    localparam int          GRANT_W       = 4;

    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
//   req   : request vector, one bit per channel
//   ptr   : last granted channel; the search starts at ptr+1 and wraps
//   idx   : index of the first requesting channel found
//   found : at least one request is set
module rr_pick
    import pack_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    int cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // i runs 1..NUM_CH so the pointer channel itself is checked last
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(ptr) + i) % NUM_CH;
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/pl2ps_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream DMA master
// between NUM_CH sources, with a per-packet stall watchdog.
//   clk, rst (async, active-low)
//   ch_en, restart            : CSR channel mask and abort pulse
//   s_tdata/s_tvalid/s_tlast/s_tready : packed per-channel source streams
//   m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready : DMA stream (registered)
//   grant_ch, busy, pkt_cnt, err_cnt : status
module pl2ps_stream_arbiter
    import pack_pkg::*;
#(
    parameter int                 NUM_CH    = 8,
    parameter int                 DATA_W    = 32,
    parameter int                 TIMEOUT   = 1024,
    parameter logic [DATA_W-1:0]  TERM_WORD = DATA_W'(TERM_WORD_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic                       restart,
    input  logic [NUM_CH*DATA_W-1:0]   s_tdata,
    input  logic [NUM_CH-1:0]          s_tvalid,
    input  logic [NUM_CH-1:0]          s_tlast,
    output logic [NUM_CH-1:0]          s_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic [DATA_W/8-1:0]        m_tkeep,
    output logic                       m_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [GRANT_W-1:0]         grant_ch,
    output logic                       busy,
    output logic [31:0]                pkt_cnt,
    output logic [15:0]                err_cnt
);

    localparam int               CH_W    = ch_idx_w(NUM_CH);
    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_found;
    logic [CNT_W-1:0]  idle_cnt;

    logic [DATA_W-1:0] data_p1;
    logic              last_p1;
    logic              vld_p1;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              out_free;
    logic              xfer_acc;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_pick (
        .req   (ch_en & s_tvalid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Stage 0: granted-channel source mux and handshake
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_data  = s_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign out_free = !vld_p1 || m_tready;
    assign xfer_acc = (state == ST_XFER) && sel_valid && out_free;

    always_comb begin
        s_tready = '0;
        if (state == ST_XFER) begin
            s_tready[grant_idx] = out_free;
        end else if (state == ST_DRAIN) begin
            // Drain swallows the rest of an abandoned packet regardless of the DMA side
            s_tready[grant_idx] = 1'b1;
        end
    end

    // Stage 1: FSM, counters and output register slice
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= LAST_CH;
            grant_idx <= '0;
            idle_cnt  <= '0;
            data_p1   <= '0;
            last_p1   <= 1'b0;
            vld_p1    <= 1'b0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            if (vld_p1 && m_tready) begin
                vld_p1 <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (restart) begin
                        rr_ptr <= LAST_CH;
                    end else if (pick_found) begin
                        grant_idx <= pick_idx;
                        rr_ptr    <= pick_idx;
                        idle_cnt  <= '0;
                        state     <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (xfer_acc) begin
                        data_p1 <= sel_data;
                        last_p1 <= sel_last;
                        vld_p1  <= 1'b1;
                    end
                    // A completing beat wins over restart: the packet is counted normally
                    if (xfer_acc && sel_last) begin
                        pkt_cnt <= pkt_cnt + 32'd1;
                        state   <= ST_IDLE;
                    end else if (restart) begin
                        state <= ST_TERM;
                    end else if (xfer_acc || (vld_p1 && !m_tready)) begin
                        // A DMA stall is not the source's fault
                        idle_cnt <= '0;
                    end else if (idle_cnt == CNT_LIM) begin
                        state <= ST_TERM;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                ST_TERM: begin
                    if (out_free) begin
                        data_p1  <= TERM_WORD;
                        last_p1  <= 1'b1;
                        vld_p1   <= 1'b1;
                        err_cnt  <= sat_inc16(err_cnt);
                        idle_cnt <= '0;
                        state    <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (sel_valid && sel_last) begin
                        state <= ST_IDLE;
                    end else if (sel_valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == CNT_LIM) begin
                        state <= ST_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            if (restart) begin
                pkt_cnt <= '0;
                err_cnt <= '0;
            end
        end
    end

    assign m_tdata  = data_p1;
    assign m_tlast  = last_p1;
    assign m_tvalid = vld_p1;
    assign m_tkeep  = '1;
    assign grant_ch = GRANT_W'(grant_idx);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_pl2ps_stream_arbiter.sv
module tb_pl2ps_stream_arbiter;

    localparam int          NUM_CH = 8;
    localparam int          DATA_W = 32;
    localparam logic [31:0] TW     = 32'hDEAD_BEEF;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_en;
    logic                     restart;
    logic [NUM_CH*DATA_W-1:0] s_tdata;
    logic [NUM_CH-1:0]        s_tvalid;
    logic [NUM_CH-1:0]        s_tlast;
    logic [NUM_CH-1:0]        s_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic [DATA_W/8-1:0]      m_tkeep;
    logic                     m_tlast;
    logic                     m_tvalid;
    logic                     m_tready;
    logic [3:0]               grant_ch;
    logic                     busy;
    logic [31:0]              pkt_cnt;
    logic [15:0]              err_cnt;

    pl2ps_stream_arbiter #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .TIMEOUT   (16),
        .TERM_WORD (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_en    (ch_en),
        .restart  (restart),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .grant_ch (grant_ch),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Source queues: {last, data} per channel
    logic [32:0] src_q [NUM_CH][$];
    logic [NUM_CH-1:0] acc_f;

    // Observed DMA beats
    logic [31:0] mon_data [$];
    logic        mon_last [$];
    logic [3:0]  mon_grant[$];
    int          mon_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        acc_f <= s_tvalid & s_tready;
        if (rst && m_tvalid && m_tready) begin
            mon_data.push_back(m_tdata);
            mon_last.push_back(m_tlast);
            mon_grant.push_back(grant_ch);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_drive();
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tlast[i]  = src_q[i][0][32];
                s_tdata[i*DATA_W +: DATA_W] = src_q[i][0][31:0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
                s_tdata[i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc_f[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        update_drive();
    endtask

    task automatic push(input int ch, input logic [31:0] d, input logic l);
        src_q[ch].push_back({l, d});
        update_drive();
    endtask

    task automatic mon_clear();
        mon_data.delete();
        mon_last.delete();
        mon_grant.delete();
        mon_cyc.delete();
    endtask

    task automatic wait_beats(input string tag, input int n, input int maxc);
        int k;
        k = 0;
        while (mon_data.size() < n && k < maxc) begin
            tick();
            k++;
        end
        chk(tag, 64'(mon_data.size() >= n), 64'd1);
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [31:0] d, input logic l);
        logic [32:0] o;
        o = 'x;
        if (idx < mon_data.size()) o = {mon_last[idx], mon_data[idx]};
        chk(tag, 64'(o), 64'({l, d}));
    endtask

    task automatic chk_grant(input string tag, input int idx, input logic [3:0] g);
        logic [3:0] o;
        o = 'x;
        if (idx < mon_grant.size()) o = mon_grant[idx];
        chk(tag, 64'(o), 64'(g));
    endtask

    logic [31:0] rr_exp_d [8];
    logic [3:0]  rr_exp_g [8];
    int          rr_gap   [7];

    initial begin
        rst      = 1'b1;
        ch_en    = '0;
        restart  = 1'b0;
        m_tready = 1'b0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        #1 rst = 1'b0;
        tick();
        tick();

        // ---------------- reset values
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'h0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        chk("rst_m_tlast",  64'(m_tlast),  64'h0);
        chk("rst_m_tdata",  64'(m_tdata),  64'h0);
        chk("rst_m_tkeep",  64'(m_tkeep),  64'hF);
        chk("rst_grant",    64'(grant_ch), 64'h0);
        chk("rst_busy",     64'(busy),     64'h0);
        chk("rst_pkt_cnt",  64'(pkt_cnt),  64'h0);
        chk("rst_err_cnt",  64'(err_cnt),  64'h0);
        tick();
        rst      = 1'b1;
        ch_en    = 8'hFF;
        m_tready = 1'b1;
        tick();

        // ---------------- single channel, ch2 sends 1,2,3,4
        mon_clear();
        push(2, 32'd1, 1'b0);
        push(2, 32'd2, 1'b0);
        push(2, 32'd3, 1'b0);
        push(2, 32'd4, 1'b1);
        @(negedge clk);
        chk("t1_idle_no_ready", 64'(s_tready), 64'h00);
        chk("t1_idle_busy",     64'(busy),     64'h0);
        tick();
        @(negedge clk);
        chk("t1_ready_after_arb", 64'(s_tready), 64'h04);
        chk("t1_grant",           64'(grant_ch), 64'h2);
        chk("t1_busy",            64'(busy),     64'h1);
        tick();
        @(negedge clk);
        chk("t1_first_out", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, 1'b0, 32'd1}));
        wait_beats("t1_wait", 4, 20);
        tick();
        tick();
        for (int i = 0; i < 4; i++) chk_beat("t1_beat", i, 32'(i + 1), (i == 3));
        chk("t1_count",   64'(mon_data.size()), 64'd4);
        chk("t1_pkt_cnt", 64'(pkt_cnt),  64'd1);
        chk("t1_grant_end", 64'(grant_ch), 64'h2);
        chk("t1_idle",    64'(busy),     64'h0);

        // ---------------- round robin from reset pointer
        restart = 1'b1;
        tick();
        restart = 1'b0;
        @(negedge clk);
        chk("t2_restart_pkt_clr", 64'(pkt_cnt), 64'd0);
        tick();
        mon_clear();
        push(0, 32'd10, 1'b0); push(0, 32'd11, 1'b1);
        push(0, 32'd12, 1'b0); push(0, 32'd13, 1'b1);
        push(3, 32'd30, 1'b0); push(3, 32'd31, 1'b1);
        push(5, 32'd50, 1'b0); push(5, 32'd51, 1'b1);
        rr_exp_d = '{32'd10, 32'd11, 32'd30, 32'd31, 32'd50, 32'd51, 32'd12, 32'd13};
        rr_exp_g = '{4'd0, 4'd0, 4'd3, 4'd3, 4'd5, 4'd5, 4'd0, 4'd0};
        rr_gap   = '{1, 2, 1, 2, 1, 2, 1};
        wait_beats("t2_wait", 8, 60);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_beat("t2_beat", i, rr_exp_d[i], (i % 2 == 1));
            chk_grant("t2_grant", i, rr_exp_g[i]);
        end
        for (int i = 0; i < 7; i++) begin
            if (i + 1 < mon_cyc.size()) chk("t2_gap", 64'(mon_cyc[i+1] - mon_cyc[i]), 64'(rr_gap[i]));
            else chk("t2_gap_missing", 64'(mon_cyc.size()), 64'd8);
        end
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // ---------------- channel mask
        mon_clear();
        ch_en = 8'b0000_0010;
        push(0, 32'd70, 1'b0); push(0, 32'd71, 1'b1);
        push(1, 32'd80, 1'b0); push(1, 32'd81, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_ready0_low", 64'(s_tready[0]), 64'h0);
            tick();
        end
        chk("t3_count", 64'(mon_data.size()), 64'd2);
        chk_beat("t3_beat0", 0, 32'd80, 1'b0);
        chk_beat("t3_beat1", 1, 32'd81, 1'b1);
        chk_grant("t3_grant", 0, 4'd1);
        chk("t3_ch0_untouched", 64'(src_q[0].size()), 64'd2);
        ch_en = 8'hFF;
        wait_beats("t3_wait_ch0", 4, 20);
        tick();
        chk_beat("t3_ch0_beat0", 2, 32'd70, 1'b0);
        chk_beat("t3_ch0_beat1", 3, 32'd71, 1'b1);
        chk_grant("t3_ch0_grant", 2, 4'd0);

        // ---------------- backpressure, m_tready 1,0,0,1 then a long stall
        tick();
        mon_clear();
        for (int i = 0; i < 6; i++) push(6, 32'(60 + i), (i == 5));
        tick();                 // arbitration
        tick();                 // accept 60
        tick();                 // accept 61, 60 leaves
        m_tready = 1'b0;
        @(negedge clk);
        chk("t4_stall1_data", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'd61}));
        chk("t4_stall1_ready", 64'(s_tready), 64'h00);
        tick();
        @(negedge clk);
        chk("t4_stall2_data", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'd61}));
        chk("t4_stall2_ready", 64'(s_tready), 64'h00);
        tick();
        m_tready = 1'b1;
        tick();                 // 61 leaves, accept 62
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        @(negedge clk);
        chk("t4_long_stall_data", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'd62}));
        chk("t4_long_stall_err",  64'(err_cnt), 64'd0);
        chk("t4_long_stall_busy", 64'(busy),    64'd1);
        tick();
        m_tready = 1'b1;
        wait_beats("t4_wait", 6, 30);
        tick();
        tick();
        chk("t4_count", 64'(mon_data.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk_beat("t4_beat", i, 32'(60 + i), (i == 5));
        chk("t4_err_cnt", 64'(err_cnt), 64'd0);
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd7);

        // ---------------- watchdog timeout on ch4
        mon_clear();
        push(4, 32'd40, 1'b0);
        push(4, 32'd41, 1'b0);
        push(4, 32'd42, 1'b0);
        wait_beats("t5_wait_term", 4, 60);
        chk_beat("t5_beat0", 0, 32'd40, 1'b0);
        chk_beat("t5_beat1", 1, 32'd41, 1'b0);
        chk_beat("t5_beat2", 2, 32'd42, 1'b0);
        chk_beat("t5_term",  3, TW,     1'b1);
        chk("t5_err_cnt", 64'(err_cnt), 64'd1);
        for (int i = 3; i < 8; i++) push(4, 32'(40 + i), (i == 7));
        for (int i = 0; i < 10; i++) tick();
        chk("t5_drained",      64'(src_q[4].size()), 64'd0);
        chk("t5_not_forwarded", 64'(mon_data.size()), 64'd4);
        chk("t5_idle",          64'(busy),    64'd0);
        chk("t5_pkt_cnt",       64'(pkt_cnt), 64'd7);
        chk("t5_err_cnt_end",   64'(err_cnt), 64'd1);

        // ---------------- restart mid-XFER
        mon_clear();
        push(7, 32'd90, 1'b0);  push(7, 32'd91, 1'b0);
        push(1, 32'd100, 1'b0); push(1, 32'd101, 1'b1);
        push(3, 32'd110, 1'b0); push(3, 32'd111, 1'b1);
        wait_beats("t6_wait_ch7", 2, 20);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        @(negedge clk);
        chk("t6_pkt_cnt_clr", 64'(pkt_cnt), 64'd0);
        chk("t6_err_cnt_clr", 64'(err_cnt), 64'd0);
        wait_beats("t6_wait_all", 7, 80);
        tick();
        chk_beat("t6_beat0", 0, 32'd90,  1'b0);
        chk_beat("t6_beat1", 1, 32'd91,  1'b0);
        chk_beat("t6_term",  2, TW,      1'b1);
        chk_beat("t6_beat3", 3, 32'd100, 1'b0);
        chk_beat("t6_beat4", 4, 32'd101, 1'b1);
        chk_beat("t6_beat5", 5, 32'd110, 1'b0);
        chk_beat("t6_beat6", 6, 32'd111, 1'b1);
        chk_grant("t6_next_grant", 3, 4'd1);
        chk_grant("t6_then_grant", 5, 4'd3);
        chk("t6_err_cnt", 64'(err_cnt), 64'd1);
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // ---------------- asynchronous reset mid-packet
        mon_clear();
        m_tready = 1'b0;
        push(2, 32'd5, 1'b0);
        push(2, 32'd6, 1'b0);
        push(2, 32'd7, 1'b0);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t7_pre_valid", 64'({m_tvalid, m_tdata}), 64'({1'b1, 32'd5}));
        #2 rst = 1'b0;
        #1;
        chk("t7_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t7_m_tdata",  64'(m_tdata),  64'd0);
        chk("t7_m_tlast",  64'(m_tlast),  64'd0);
        chk("t7_s_tready", 64'(s_tready), 64'd0);
        chk("t7_busy",     64'(busy),     64'd0);
        chk("t7_grant",    64'(grant_ch), 64'd0);
        chk("t7_pkt_cnt",  64'(pkt_cnt),  64'd0);
        chk("t7_err_cnt",  64'(err_cnt),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
